regfile_wb_queue: RTL

//   Writeback-side initiator for the dual-write-port register file. Buffers results

---
 rtl/regfile_wb_queue.sv | 129 ++++++++++++
 1 files changed

// File: rtl/regfile_wb_queue.sv
// Writeback queue feeding the dual-write-port register file.
// Buffers A/B results in order and drains up to two per cycle onto x/y.
module regfile_wb_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [4:0]    a_rn,
    input  logic [31:0]   a_d,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [4:0]    b_rn,
    input  logic [31:0]   b_d,
    input  logic          stall,
    output logic [4:0]    wnx,
    output logic [31:0]   dx,
    output logic          wex,
    output logic [4:0]    wny,
    output logic [31:0]   dy,
    output logic          wey,
    input  logic [4:0]    pend_rn,
    output logic          pend,
    output logic [AW:0]   count
);

    localparam logic [AW:0] LIM_A = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] LIM_B = (AW+1)'(DEPTH - 2);

    logic [4:0]    rn_q [DEPTH];
    logic [31:0]   d_q  [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_nxt;
    logic [AW-1:0] wr_b;
    logic          push_a;
    logic          push_b;
    logic [AW:0]   n_push;
    logic [AW:0]   n_pop;
    logic          hit;

    // Ready depends only on the registered count.
    assign a_ready = (count <= LIM_A);
    assign b_ready = (count <= LIM_B);

    // Handshake, push/pop amounts and slot addresses; $0 results are dropped.
    always_comb begin
        push_a = a_valid && a_ready && (a_rn != 5'd0);
        push_b = b_valid && b_ready && (b_rn != 5'd0);
        n_push = (AW+1)'(push_a) + (AW+1)'(push_b);
        n_pop  = '0;
        if (!stall) begin
            if (count >= (AW+1)'(2)) n_pop = (AW+1)'(2);
            else                     n_pop = count;
        end
        rd_nxt = rd_ptr + AW'(1);
        wr_b   = wr_ptr + AW'(push_a);
    end

    // Entry storage; B lands behind A when both are accepted.
    always_ff @(posedge clk) begin
        if (push_a) begin
            rn_q[wr_ptr] <= a_rn;
            d_q[wr_ptr]  <= a_d;
        end
        if (push_b) begin
            rn_q[wr_b] <= b_rn;
            d_q[wr_b]  <= b_d;
        end
    end

    // Pointers and occupancy; drain uses only the pre-edge count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= count + n_push - n_pop;
            wr_ptr <= wr_ptr + AW'(n_push);
            rd_ptr <= rd_ptr + AW'(n_pop);
        end
    end

    // Registered write ports: head on x, head+1 on y.
    always_ff @(posedge clk) begin
        if (rst) begin
            wex <= 1'b0;
            wnx <= '0;
            dx  <= '0;
            wey <= 1'b0;
            wny <= '0;
            dy  <= '0;
        end else begin
            wex <= 1'b0;
            wnx <= '0;
            dx  <= '0;
            wey <= 1'b0;
            wny <= '0;
            dy  <= '0;
            if (n_pop != '0) begin
                wex <= 1'b1;
                wnx <= rn_q[rd_ptr];
                dx  <= d_q[rd_ptr];
            end
            if (n_pop == (AW+1)'(2)) begin
                wey <= 1'b1;
                wny <= rn_q[rd_nxt];
                dy  <= d_q[rd_nxt];
            end
        end
    end

    // Pending-write lookup over occupied slots and the driven ports.
    always_comb begin
        logic [AW-1:0] off;
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rd_ptr;
            if (({1'b0, off} < count) && (rn_q[i] == pend_rn)) hit = 1'b1;
        end
        pend = (pend_rn != 5'd0) &&
               (hit || (wex && (wnx == pend_rn)) || (wey && (wny == pend_rn)));
    end

endmodule
